beam_frame_ctrl: RTL and testbench

//  Sequences the four-channel beam-combining adder: joins the NUM_CH input streams into lock-step beats,

---
 rtl/beam_ctrl_pkg.sv | 15 +
 rtl/beam_weight_bank.sv | 52 +++++
 rtl/beam_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_beam_frame_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/beam_ctrl_pkg.sv
// rtl/beam_ctrl_pkg.sv - shared types and defaults for the beam frame controller
package beam_ctrl_pkg;

   localparam int WEIGHT_WIDTH_DEF = 8;
   localparam logic [WEIGHT_WIDTH_DEF-1:0] WEIGHT_RST_DEF = 8'h7F;

   typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

   // Field order mirrors the cfg_wdata layout {imag, real}.
   typedef struct packed {
      logic [WEIGHT_WIDTH_DEF-1:0] im;
      logic [WEIGHT_WIDTH_DEF-1:0] re;
   } weight_t;

endpackage

// File: rtl/beam_weight_bank.sv
// rtl/beam_weight_bank.sv - double-buffered per-channel complex beam weights
module beam_weight_bank
   import beam_ctrl_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_RST = WEIGHT_RST_DEF
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic                             we,
   input  logic [$clog2(NUM_CH)-1:0]        addr,
   input  logic [2*WEIGHT_WIDTH-1:0]        wdata,
   input  logic                             swap,
   output logic [NUM_CH*WEIGHT_WIDTH-1:0]   w_real,
   output logic [NUM_CH*WEIGHT_WIDTH-1:0]   w_imag
);

   logic [WEIGHT_WIDTH-1:0] sh_re [NUM_CH];
   logic [WEIGHT_WIDTH-1:0] sh_im [NUM_CH];
   logic [WEIGHT_WIDTH-1:0] ac_re [NUM_CH];
   logic [WEIGHT_WIDTH-1:0] ac_im [NUM_CH];

   // The copy reads the old shadow, so a write landing in the swap cycle waits for the next swap.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sh_re[i] <= WEIGHT_RST;
            sh_im[i] <= '0;
            ac_re[i] <= WEIGHT_RST;
            ac_im[i] <= '0;
         end
      end else begin
         if (swap) begin
            for (int i = 0; i < NUM_CH; i++) begin
               ac_re[i] <= sh_re[i];
               ac_im[i] <= sh_im[i];
            end
         end
         if (we) begin
            sh_re[addr] <= wdata[WEIGHT_WIDTH-1:0];
            sh_im[addr] <= wdata[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign w_real[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = ac_re[g];
      assign w_imag[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = ac_im[g];
   end

endmodule

// File: rtl/beam_frame_ctrl.sv
// rtl/beam_frame_ctrl.sv - joins channel streams, frames adder beats, swaps weights at frame edges
// Optional skew monitor enabled by defining BEAM_SKEW_MON_EN.
module beam_frame_ctrl
   import beam_ctrl_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int LEN_WIDTH = 16,
   parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_RST = WEIGHT_RST_DEF,
   parameter int SKEW_LIMIT = 64
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic                             enable,
   input  logic [LEN_WIDTH-1:0]             frame_len,
   input  logic [NUM_CH-1:0]                s_valid,
   input  logic [NUM_CH-1:0]                s_last,
   output logic [NUM_CH-1:0]                s_ready,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             m_last,
   input  logic                             cfg_we,
   input  logic [$clog2(NUM_CH)-1:0]        cfg_addr,
   input  logic [2*WEIGHT_WIDTH-1:0]        cfg_wdata,
   input  logic                             cfg_commit,
   output logic [NUM_CH*WEIGHT_WIDTH-1:0]   w_real,
   output logic [NUM_CH*WEIGHT_WIDTH-1:0]   w_imag,
   output logic                             commit_pending,
   output logic [LEN_WIDTH-1:0]             frame_cnt,
   input  logic                             err_clr,
   output logic                             err_last,
   output logic                             err_skew
);

   state_t               state;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [LEN_WIDTH-1:0] len_next;
   logic                 fire;

   assign len_next = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
   assign m_valid  = (state == RUN) & (&s_valid);
   assign m_last   = m_valid & (beat_cnt == len_q - LEN_WIDTH'(1));
   assign fire     = m_valid & m_ready;
   assign s_ready  = {NUM_CH{fire}};

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state          <= IDLE;
         len_q          <= LEN_WIDTH'(1);
         beat_cnt       <= '0;
         frame_cnt      <= '0;
         commit_pending <= 1'b0;
         err_last       <= 1'b0;
      end else begin
         // A commit arriving during the swap stays pending for the next frame boundary.
         if (cfg_commit)
            commit_pending <= 1'b1;
         else if (state == SWAP)
            commit_pending <= 1'b0;

         case (state)
            IDLE: begin
               if (commit_pending) begin
                  state <= SWAP;
               end else if (enable) begin
                  len_q    <= len_next;
                  beat_cnt <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (fire) begin
                  if (m_last) begin
                     beat_cnt  <= '0;
                     frame_cnt <= frame_cnt + LEN_WIDTH'(1);
                     if (commit_pending || cfg_commit)
                        state <= SWAP;
                     else if (!enable)
                        state <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                  end
               end
            end
            SWAP: begin
               if (enable) begin
                  len_q    <= len_next;
                  beat_cnt <= '0;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (fire && (s_last != {NUM_CH{m_last}}))
            err_last <= 1'b1;
         else if (err_clr)
            err_last <= 1'b0;
      end
   end

   beam_weight_bank #(
      .NUM_CH       (NUM_CH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .WEIGHT_RST   (WEIGHT_RST)
   ) u_bank (
      .clock  (clock),
      .resetn (resetn),
      .we     (cfg_we),
      .addr   (cfg_addr),
      .wdata  (cfg_wdata),
      .swap   (state == SWAP),
      .w_real (w_real),
      .w_imag (w_imag)
   );

`ifdef BEAM_SKEW_MON_EN
   localparam logic [LEN_WIDTH-1:0] SKEW_MAX = LEN_WIDTH'(SKEW_LIMIT - 1);
   logic [LEN_WIDTH-1:0] skew_cnt;
   logic                 skew_err_q;
   logic                 skewed;

   assign skewed = (state == RUN) & (|s_valid) & ~(&s_valid);

   // Counter saturates one short of the limit; the error re-arms every cycle skew persists.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         skew_cnt   <= '0;
         skew_err_q <= 1'b0;
      end else begin
         if (!skewed)
            skew_cnt <= '0;
         else if (skew_cnt != SKEW_MAX)
            skew_cnt <= skew_cnt + LEN_WIDTH'(1);
         if (skewed && (skew_cnt == SKEW_MAX))
            skew_err_q <= 1'b1;
         else if (err_clr)
            skew_err_q <= 1'b0;
      end
   end

   assign err_skew = skew_err_q;
`else
   logic unused_skew_limit;
   assign unused_skew_limit = (SKEW_LIMIT != 0);
   assign err_skew = 1'b0;
`endif

endmodule

// File: tb/tb_beam_frame_ctrl.sv
// tb/tb_beam_frame_ctrl.sv - randomized and directed bench for beam_frame_ctrl against a frame-level model
module tb_beam_frame_ctrl;

   localparam int LIMIT = 8;

   logic        clock = 1'b0;
   logic        resetn, enable, m_ready, m_valid, m_last;
   logic [15:0] frame_len, frame_cnt, cfg_wdata;
   logic [3:0]  s_valid, s_last, s_ready;
   logic        cfg_we, cfg_commit, commit_pending, err_clr, err_last, err_skew;
   logic [1:0]  cfg_addr;
   logic [31:0] w_real, w_imag;

   always #5 clock = ~clock;

   beam_frame_ctrl #(.SKEW_LIMIT(LIMIT)) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .frame_len(frame_len),
      .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
      .w_real(w_real), .w_imag(w_imag), .commit_pending(commit_pending),
      .frame_cnt(frame_cnt), .err_clr(err_clr), .err_last(err_last), .err_skew(err_skew)
   );

   int n_vec = 0;
   int n_err = 0;

   bit          md_run, md_swap, md_pend, md_errl, md_errs;
   int          md_len, md_beat, md_frames, md_skew;
   logic [7:0]  sh_re [4], sh_im [4], ac_re [4], ac_im [4];
   bit          auto_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic md_reset();
      md_run = 0; md_swap = 0; md_pend = 0; md_errl = 0; md_errs = 0;
      md_len = 1; md_beat = 0; md_frames = 0; md_skew = 0;
      for (int i = 0; i < 4; i++) begin
         sh_re[i] = 8'h7F; sh_im[i] = 8'h00; ac_re[i] = 8'h7F; ac_im[i] = 8'h00;
      end
   endtask

   task automatic md_start();
      md_run  = 1;
      md_len  = (frame_len == 0) ? 1 : int'(frame_len);
      md_beat = 0;
   endtask

   // One clock: predict outputs, compare, advance the model, wait for the next edge.
   task automatic step();
      bit          e_mv, e_ml, fire, skewed, new_pend;
      logic [31:0] e_re, e_im;
      e_mv = md_run && (s_valid == 4'hF);
      e_ml = e_mv && (md_beat == md_len - 1);
      fire = e_mv && m_ready;
      if (auto_last) s_last = e_ml ? 4'hF : 4'h0;
      #1;
      for (int i = 0; i < 4; i++) begin
         e_re[i*8 +: 8] = ac_re[i];
         e_im[i*8 +: 8] = ac_im[i];
      end
      check("m_valid", 32'(m_valid), 32'(e_mv));
      check("m_last", 32'(m_last), 32'(e_ml));
      check("s_ready", 32'(s_ready), fire ? 32'hF : 32'h0);
      check("commit_pending", 32'(commit_pending), 32'(md_pend));
      check("frame_cnt", 32'(frame_cnt), 32'(md_frames));
      check("err_last", 32'(err_last), 32'(md_errl));
      check("err_skew", 32'(err_skew), 32'(md_errs));
      check("w_real", w_real, e_re);
      check("w_imag", w_imag, e_im);
      if (!resetn) begin
         md_reset();
      end else begin
         skewed  = md_run && (s_valid != 4'h0) && (s_valid != 4'hF);
         md_skew = skewed ? md_skew + 1 : 0;
         if (fire && (s_last != (e_ml ? 4'hF : 4'h0))) md_errl = 1;
         else if (err_clr) md_errl = 0;
`ifdef BEAM_SKEW_MON_EN
         if (skewed && md_skew >= LIMIT) md_errs = 1;
         else if (err_clr) md_errs = 0;
`endif
         new_pend = cfg_commit ? 1'b1 : (md_swap ? 1'b0 : md_pend);
         if (md_swap) begin
            for (int i = 0; i < 4; i++) begin
               ac_re[i] = sh_re[i]; ac_im[i] = sh_im[i];
            end
            md_swap = 0;
            if (enable) md_start();
         end else if (md_run) begin
            if (fire && e_ml) begin
               md_beat   = 0;
               md_frames = (md_frames + 1) % 65536;
               if (md_pend || cfg_commit) begin md_run = 0; md_swap = 1; end
               else if (!enable) md_run = 0;
            end else if (fire) begin
               md_beat++;
            end
         end else if (md_pend) begin
            md_swap = 1;
         end else if (enable) begin
            md_start();
         end
         if (cfg_we) begin
            sh_re[cfg_addr] = cfg_wdata[7:0];
            sh_im[cfg_addr] = cfg_wdata[15:8];
         end
         md_pend = new_pend;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic defaults();
      resetn = 1; enable = 0; frame_len = 16'd4; s_valid = 4'hF; s_last = 4'h0; m_ready = 1;
      cfg_we = 0; cfg_addr = 2'd0; cfg_wdata = 16'h0; cfg_commit = 0; err_clr = 0; auto_last = 1;
   endtask

   initial begin
      defaults();
      resetn = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      md_reset();
      #1;
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_s_ready", 32'(s_ready), 32'h0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      check("rst_w_real", w_real, 32'h7F7F7F7F);
      check("rst_w_imag", w_imag, 32'h0);
      check("rst_errors", {30'h0, err_last, err_skew}, 32'h0);
      resetn = 1;

      // Single 4-beat frame, enable dropped after start.
      enable = 1; step(); enable = 0;
      repeat (4) step();
      check("t1_frames", 32'(frame_cnt), 32'd1);

      // Channel 3 late: no fire until all valid.
      enable = 1; step(); enable = 0;
      s_valid = 4'b0111; repeat (5) step();
      check("t2_hold_frames", 32'(frame_cnt), 32'd1);
      s_valid = 4'hF; repeat (4) step();
      check("t2_frames", 32'(frame_cnt), 32'd2);

      // Weight write and commit mid-frame.
      cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 16'h1020; enable = 1; step();
      cfg_we = 0; enable = 0; step();
      cfg_commit = 1; step(); cfg_commit = 0;
      check("t3_pending", 32'(commit_pending), 32'd1);
      check("t3_hold_mid", 32'(w_real[23:16]), 32'h7F);
      step(); step();
      check("t3_hold_last", 32'(w_real[23:16]), 32'h7F);
      step();
      check("t3_real", 32'(w_real[23:16]), 32'h20);
      check("t3_imag", 32'(w_imag[23:16]), 32'h10);
      check("t3_pending_clr", 32'(commit_pending), 32'd0);

      // Backpressure on alternate cycles.
      enable = 1; step(); enable = 0;
      for (int i = 0; i < 8; i++) begin m_ready = i[0]; step(); end
      m_ready = 1;
      check("t4_frames", 32'(frame_cnt), 32'd4);

      // Bad s_last on beat 2.
      enable = 1; step(); enable = 0;
      step();
      auto_last = 0; s_last = 4'b0001; step(); auto_last = 1;
      check("t5_err_set", 32'(err_last), 32'd1);
      step(); step();
      check("t5_err_sticky", 32'(err_last), 32'd1);
      err_clr = 1; step(); err_clr = 0;
      check("t5_err_clr", 32'(err_last), 32'd0);

      // Skew held for LIMIT cycles.
      enable = 1; step(); enable = 0;
      s_valid = 4'b0011; repeat (LIMIT) step();
`ifdef BEAM_SKEW_MON_EN
      check("t6_skew", 32'(err_skew), 32'd1);
`else
      check("t6_skew", 32'(err_skew), 32'd0);
`endif
      s_valid = 4'hF; repeat (4) step();
      err_clr = 1; step(); err_clr = 0;
      check("t6_skew_clr", 32'(err_skew), 32'd0);

      // Reset mid-frame discards the partial frame.
      enable = 1; step(); step(); step();
      resetn = 0; step(); resetn = 1; enable = 0;
      check("rst_mid_frames", 32'(frame_cnt), 32'd0);
      check("rst_mid_w_real", w_real, 32'h7F7F7F7F);

      for (int c = 0; c < 3000; c++) begin
         resetn     = ($urandom_range(0, 499) != 0);
         enable     = ($urandom_range(0, 3) != 0);
         frame_len  = 16'($urandom_range(0, 5));
         s_valid    = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
         m_ready    = ($urandom_range(0, 3) != 0);
         cfg_we     = ($urandom_range(0, 7) == 0);
         cfg_addr   = 2'($urandom);
         cfg_wdata  = 16'($urandom);
         cfg_commit = ($urandom_range(0, 31) == 0);
         err_clr    = ($urandom_range(0, 15) == 0);
         auto_last  = ($urandom_range(0, 19) != 0);
         if (!auto_last) s_last = 4'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
